// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one PC register, a one-word hold buffer and a pending-redirect slot.
// Optional macro IF_ADEL_CHECK_EN adds an instruction address-error check on the fetch PC.
module if_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_exc_adel
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        adel_s;
  logic        advance_s;
  logic [31:0] pc_next_s;

`ifdef IF_ADEL_CHECK_EN
  function automatic logic adel_f(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < 32'h0000_3000) || (addr > 32'h0000_6FFC);
  endfunction

  assign adel_s = adel_f(pc_q);
`else
  assign adel_s = 1'b0;
`endif

  assign im_addr   = {pc_q[31:2], 2'b00};
  assign F_pc      = pc_q;
  assign advance_s = F_valid && en;

  // Presentation outputs; forced quiet while reset is held low.
  always_comb begin
    im_req     = 1'b0;
    F_valid    = 1'b0;
    F_instr    = im_rdata;
    F_exc_adel = 1'b0;
    if (!reset) begin
      F_instr = 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (adel_s) begin
            F_valid    = 1'b1;
            F_instr    = 32'd0;
            F_exc_adel = 1'b1;
          end else begin
            im_req  = 1'b1;
            F_valid = im_ready;
            F_instr = im_rdata;
          end
        end
        HOLD: begin
          F_valid = 1'b1;
          F_instr = buf_q;
        end
        default: begin
          F_instr = 32'd0;
        end
      endcase
    end
  end

  // Redirect wins over a parked redirect, which wins over sequential fetch.
  always_comb begin
    pc_next_s = pc_q + 32'd4;
    if (redirect) begin
      pc_next_s = redirect_pc;
    end else if (pend_valid_q) begin
      pc_next_s = pend_pc_q;
    end else begin
      pc_next_s = pc_q + 32'd4;
    end
  end

  // Next-state: advance, capture into the hold buffer, or park a redirect.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (advance_s) begin
      state_d      = FETCH;
      pc_d         = pc_next_s;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (im_ready && !adel_s) begin
            buf_d   = im_rdata;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
      if (redirect) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redirect_pc;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scoreboard bench for if_fetch_unit; expectations queued per step, popped at the sample edge.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        F_valid;
  logic        F_exc_adel;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  if_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ready   (im_ready),
    .im_rdata   (im_rdata),
    .F_pc       (F_pc),
    .F_instr    (F_instr),
    .F_valid    (F_valid),
    .F_exc_adel (F_exc_adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic rdy,
                      input logic rd, input logic [31:0] rpc, input logic [31:0] rdat,
                      input logic x_req, input logic [31:0] x_addr, input logic x_valid,
                      input logic [31:0] x_instr, input logic [31:0] x_pc, input logic x_exc);
    exp_t x;
    reset = r; en = e; im_ready = rdy; redirect = rd; redirect_pc = rpc; im_rdata = rdat;
    sb.push_back('{tag, x_req, x_addr, x_valid, x_instr, x_pc, x_exc});
    @(negedge clk);
    x = sb.pop_front();
    cmp(x.tag, "im_req", {31'd0, im_req}, {31'd0, x.req});
    cmp(x.tag, "im_addr", im_addr, x.addr);
    cmp(x.tag, "F_valid", {31'd0, F_valid}, {31'd0, x.valid});
    if (x.valid) cmp(x.tag, "F_instr", F_instr, x.instr);
    cmp(x.tag, "F_pc", F_pc, x.pc);
    cmp(x.tag, "F_exc_adel", {31'd0, F_exc_adel}, {31'd0, x.exc});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; en = 1'b1; im_ready = 1'b1; redirect = 1'b0;
    redirect_pc = 32'd0; im_rdata = 32'd0;
    #1;
    // tag       rst  en   rdy  redir redirect_pc     rdata                req  addr            valid instr               pc              exc
    step("rst",   1'b0,1'b1,1'b1,1'b0, 32'd0,          w(32'h3000),         1'b0,32'h0000_3000, 1'b0, 32'd0,              32'h0000_3000, 1'b0);
    step("seq0",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3000),         1'b1,32'h0000_3000, 1'b1, w(32'h3000),        32'h0000_3000, 1'b0);
    step("seq1",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3004),         1'b1,32'h0000_3004, 1'b1, w(32'h3004),        32'h0000_3004, 1'b0);
    step("seq2",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3008),         1'b1,32'h0000_3008, 1'b1, w(32'h3008),        32'h0000_3008, 1'b0);
    step("dslot", 1'b1,1'b1,1'b1,1'b1, 32'h0000_3004,  w(32'h300C),         1'b1,32'h0000_300C, 1'b1, w(32'h300C),        32'h0000_300C, 1'b0);
    for (int i = 0; i < 3; i++)
      step("wait",1'b1,1'b1,1'b0,1'b0, 32'd0,          32'h1111_1111,       1'b1,32'h0000_3004, 1'b0, 32'd0,              32'h0000_3004, 1'b0);
    step("wdone", 1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3004),         1'b1,32'h0000_3004, 1'b1, w(32'h3004),        32'h0000_3004, 1'b0);
    step("cap",   1'b1,1'b0,1'b1,1'b0, 32'd0,          w(32'h3008),         1'b1,32'h0000_3008, 1'b1, w(32'h3008),        32'h0000_3008, 1'b0);
    step("hold1", 1'b1,1'b0,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3008, 1'b1, w(32'h3008),        32'h0000_3008, 1'b0);
    step("hold2", 1'b1,1'b0,1'b0,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3008, 1'b1, w(32'h3008),        32'h0000_3008, 1'b0);
    step("hadv",  1'b1,1'b1,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3008, 1'b1, w(32'h3008),        32'h0000_3008, 1'b0);
    step("pc4",   1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h300C),         1'b1,32'h0000_300C, 1'b1, w(32'h300C),        32'h0000_300C, 1'b0);
    step("cap2",  1'b1,1'b0,1'b1,1'b0, 32'd0,          w(32'h3010),         1'b1,32'h0000_3010, 1'b1, w(32'h3010),        32'h0000_3010, 1'b0);
    step("hredir",1'b1,1'b0,1'b1,1'b1, 32'h0000_3100,  32'hDEAD_BEEF,       1'b0,32'h0000_3010, 1'b1, w(32'h3010),        32'h0000_3010, 1'b0);
    step("hpend", 1'b1,1'b0,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3010, 1'b1, w(32'h3010),        32'h0000_3010, 1'b0);
    step("padv",  1'b1,1'b1,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3010, 1'b1, w(32'h3010),        32'h0000_3010, 1'b0);
    step("ptgt",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3100),         1'b1,32'h0000_3100, 1'b1, w(32'h3100),        32'h0000_3100, 1'b0);
    step("pclr",  1'b1,1'b1,1'b1,1'b1, 32'h0000_3040,  w(32'h3104),         1'b1,32'h0000_3104, 1'b1, w(32'h3104),        32'h0000_3104, 1'b0);
    step("cap3",  1'b1,1'b0,1'b1,1'b0, 32'd0,          w(32'h3040),         1'b1,32'h0000_3040, 1'b1, w(32'h3040),        32'h0000_3040, 1'b0);
    step("hold3", 1'b1,1'b0,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3040, 1'b1, w(32'h3040),        32'h0000_3040, 1'b0);
    step("midrst",1'b0,1'b1,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_3000, 1'b0, 32'd0,              32'h0000_3000, 1'b0);
    step("rel0",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h3000),         1'b1,32'h0000_3000, 1'b1, w(32'h3000),        32'h0000_3000, 1'b0);
`ifdef IF_ADEL_CHECK_EN
    step("r3002", 1'b1,1'b1,1'b1,1'b1, 32'h0000_3002,  w(32'h3004),         1'b1,32'h0000_3004, 1'b1, w(32'h3004),        32'h0000_3004, 1'b0);
    step("adel",  1'b1,1'b1,1'b1,1'b1, 32'h0000_6FFC,  32'hDEAD_BEEF,       1'b0,32'h0000_3000, 1'b1, 32'd0,              32'h0000_3002, 1'b1);
    step("top",   1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h6FFC),         1'b1,32'h0000_6FFC, 1'b1, w(32'h6FFC),        32'h0000_6FFC, 1'b0);
    step("over",  1'b1,1'b1,1'b1,1'b0, 32'd0,          32'hDEAD_BEEF,       1'b0,32'h0000_7000, 1'b1, 32'd0,              32'h0000_7000, 1'b1);
`else
    step("rwrap", 1'b1,1'b1,1'b1,1'b1, 32'hFFFF_FFFC,  w(32'h3004),         1'b1,32'h0000_3004, 1'b1, w(32'h3004),        32'h0000_3004, 1'b0);
    step("last",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'hFFFF_FFFC),    1'b1,32'hFFFF_FFFC, 1'b1, w(32'hFFFF_FFFC),   32'hFFFF_FFFC, 1'b0);
    step("wrap",  1'b1,1'b1,1'b1,1'b0, 32'd0,          w(32'h0),            1'b1,32'h0000_0000, 1'b1, w(32'h0),           32'h0000_0000, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have reset, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have en, input, 1, downstream-accept / stall control; 0 holds the stage.
REQ-004 The block SHALL have redirect, input, 1, a one-cycle pulse: the branch/jump is taken.
REQ-005 The block SHALL have redirect_pc, input, 32, the branch/jump target.
REQ-006 The block SHALL have im_req, output, 1, the instruction-memory request.
REQ-007 The block SHALL have im_addr, output, 32, the fetch address, word-aligned.
REQ-008 The block SHALL have im_ready, input, 1, which marks im_rdata valid in the current cycle.
REQ-009 The block SHALL have im_rdata, input, 32, the fetched instruction word.
REQ-010 The block SHALL have F_pc, output, 32, the PC of the presented instruction.
REQ-011 The block SHALL have F_instr, output, 32, the presented instruction.
REQ-012 The block SHALL have F_valid, output, 1, which marks F_instr/F_pc as valid.
REQ-013 The block SHALL have F_exc_adel, output, 1, the instruction address-error flag.

Function
REQ-014 The block SHALL hold state registers pc[31:0], buf[31:0], pend_valid, pend_pc[31:0], and a 2-state FSM {FETCH, HOLD}.
REQ-015 im_addr SHALL be {pc[31:2],2'b00}, and F_pc SHALL be pc.
REQ-016 im_req SHALL be 1 exactly in FETCH, with the exception given in REQ-030.
REQ-017 F_valid SHALL be (FETCH && im_ready) || HOLD.
REQ-018 F_instr SHALL be im_rdata in FETCH and buf in HOLD.
REQ-019 Advance SHALL be defined as F_valid && en.
- On the edge of an advance, the FSM goes to FETCH.
- pc loads its next-PC value per REQ-022.
REQ-020 FETCH with im_ready && !en SHALL buf <= im_rdata and go to HOLD; pc is unchanged.
REQ-021 HOLD with !en SHALL keep all state unchanged, and im_ready SHALL be ignored in HOLD.
REQ-022 Next-PC priority SHALL be:
- redirect => redirect_pc;
- else pend_valid => pend_pc;
- else pc + 4, modulo 2^32 with wrap permitted.
REQ-023 The following rules SHALL apply to redirect when there is no advance:
- If redirect is asserted without an advance: pend_valid <= 1 and pend_pc <= redirect_pc.
- A later redirect overwrites pend_pc.
REQ-024 Every advance SHALL clear pend_valid.
REQ-025 Latency SHALL be as follows:
- With zero-wait memory (im_ready=1) and en=1, one instruction is presented per cycle.
- F_valid rises in the same cycle as im_ready.
REQ-026 A stall during a memory wait (FETCH, im_ready=0) SHALL keep im_req asserted on the same im_addr.
REQ-027 redirect SHALL target the instruction after the one presented at the time of the advance (delay-slot semantics). The instruction currently presented is never squashed.

Reset
REQ-028 While reset=0 the block SHALL hold the following values asynchronously:
- pc = 32'h0000_3000, buf = 0, pend_valid = 0, pend_pc = 0, FSM = FETCH.
- Outputs: F_valid = 0, im_req = 0, F_exc_adel = 0.
REQ-029 The following rules SHALL apply to reset during operation and on release:
- Reset asserted mid-wait or in HOLD discards the buffered or pending state.
- The first edge after release presents im_req=1, im_addr=32'h0000_3000.

Configuration
REQ-030 The following behaviour SHALL apply when macro IF_ADEL_CHECK_EN is defined:
- adel = (pc[1:0] != 0) || pc < 32'h0000_3000 || pc > 32'h0000_6FFC.
- While adel is true in FETCH: im_req=0, F_valid=1, F_instr=0, F_exc_adel=1.
- Advance proceeds per REQ-019/REQ-022.
REQ-031 When IF_ADEL_CHECK_EN is undefined, F_exc_adel SHALL be tied 0, and pc SHALL never block a fetch.

Verification
REQ-032 The bench SHALL cover reset release with im_ready=1 and en=1 held: im_addr SHALL be 0x3000, 0x3004, 0x3008 on consecutive cycles, with F_valid=1 each cycle.
REQ-033 The bench SHALL cover im_ready=0 for 3 cycles at pc 0x3004: im_req=1 and im_addr=0x3004 SHALL be held and F_valid=0; on im_ready=1, F_valid=1 and F_instr=im_rdata.
REQ-034 The bench SHALL cover im_ready=1 with en=0 for 2 cycles, with im_rdata changing to 0xDEADBEEF during the stall: F_instr SHALL stay at the first word; after en=1, the next im_addr SHALL be pc+4.
REQ-035 The bench SHALL cover redirect pulse to 0x3100 while the FSM is in HOLD (en=0): once en=1, the next im_addr SHALL be 0x3100, and pend_valid SHALL be cleared.
REQ-036 The bench SHALL cover reset low asserted mid-HOLD at pc 0x3040: outputs SHALL clear immediately; after release, im_addr SHALL be 0x3000.
REQ-037 If IF_ADEL_CHECK_EN is defined, the bench SHALL cover redirect to 0x3002: the following cycle SHALL show im_req=0, F_valid=1, F_instr=0, F_exc_adel=1, F_pc=0x3002.
